// File: rtl/lcd_key_cmd.sv
// Front-panel key to LCD command source: per-key sync/debounce, priority encode,
// one-deep pending slot and a hold/timeout handshake against the controller state.
// Optional auto-repeat of a single held key is enabled by defining KEY_REPEAT_EN.
module lcd_key_cmd #(
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter int unsigned HOLD_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES  = 4096,
  parameter logic [3:0]  IDLE_CODE       = 4'b0110,
  parameter int unsigned REPEAT_DELAY    = 500000,
  parameter int unsigned REPEAT_PERIOD   = 100000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [6:0] keys,
  input  logic [3:0] lcd_state,
  output logic [2:0] lcdctl,
  output logic       busy,
  output logic       dropped,
  output logic       timeout
);

  localparam int unsigned NK   = 7;
  localparam int unsigned DW   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned TMAX = (TIMEOUT_CYCLES > HOLD_CYCLES) ? TIMEOUT_CYCLES : HOLD_CYCLES;
  localparam int unsigned TW   = (TMAX > 2) ? $clog2(TMAX) : 1;

  if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1 || TIMEOUT_CYCLES < 1 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("lcd_key_cmd: cycle count parameters must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_HOLD      = 2'd2,
    S_DONE_WAIT = 2'd3
  } state_e;

  logic [NK-1:0] sync1_q, sync2_q;
  logic [NK-1:0] deb_q, deb_d;
  logic [NK-1:0] press_q, press_d;
  logic [DW-1:0] db_cnt_q [NK];
  logic [DW-1:0] db_cnt_d [NK];
  logic [NK-1:0] rep_evt;

  state_e        state_q, state_d;
  logic [2:0]    cmd_q, cmd_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          slot_vld_q, slot_vld_d;
  logic [2:0]    slot_cmd_q, slot_cmd_d;
  logic [2:0]    lcdctl_q, lcdctl_d;
  logic          busy_q, busy_d;
  logic          dropped_q, dropped_d;
  logic          timeout_q, timeout_d;

  logic [NK-1:0] evt;
  logic          evt_any, evt_multi, consume;
  logic [2:0]    evt_cmd;

  // Debounce: level follows the synchroniser only after DEBOUNCE_CYCLES of stable mismatch
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < NK; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (db_cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) deb_d[i] = sync2_q[i];
        else db_cnt_d[i] = db_cnt_q[i] + DW'(1);
      end
    end
    press_d = deb_d & ~deb_q;
  end

`ifdef KEY_REPEAT_EN
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW   = (RMAX > 2) ? $clog2(RMAX) : 1;

  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          rep_first_q, rep_first_d;
  logic [NK-1:0] rep_evt_q, rep_evt_d;
  logic          one_hot;

  // Repeat timer runs only while one key stays down and the pressed set is unchanged
  always_comb begin
    rep_cnt_d   = '0;
    rep_first_d = 1'b1;
    rep_evt_d   = '0;
    one_hot     = (deb_q != '0) && ((deb_q & (deb_q - NK'(1))) == '0);
    if (one_hot && (deb_d == deb_q)) begin
      rep_first_d = rep_first_q;
      if (rep_cnt_q == (rep_first_q ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1))) begin
        rep_evt_d   = deb_q;
        rep_first_d = 1'b0;
      end else begin
        rep_cnt_d = rep_cnt_q + RW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
      rep_evt_q   <= '0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
      rep_evt_q   <= rep_evt_d;
    end
  end

  assign rep_evt = rep_evt_q;
`else
  assign rep_evt = '0;
`endif

  assign evt = press_q | rep_evt;

  // Lowest key index wins; any other simultaneous event is discarded
  always_comb begin
    evt_cmd   = 3'b000;
    evt_any   = |evt;
    evt_multi = (evt & (evt - NK'(1))) != '0;
    for (int i = NK - 1; i >= 0; i--) begin
      if (evt[i]) evt_cmd = 3'(i + 1);
    end
  end

  assign consume = (state_q == S_IDLE) && slot_vld_q && (lcd_state == IDLE_CODE);

  // Pending slot: a consume in the same cycle frees room for the new event
  always_comb begin
    slot_vld_d = slot_vld_q;
    slot_cmd_d = slot_cmd_q;
    dropped_d  = evt_multi;
    if (consume) slot_vld_d = 1'b0;
    if (evt_any) begin
      if (!slot_vld_q || consume) begin
        slot_vld_d = 1'b1;
        slot_cmd_d = evt_cmd;
      end else begin
        dropped_d = 1'b1;
      end
    end
  end

  // Command handshake FSM; outputs are computed from the next state so they register cleanly
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    timer_d   = timer_q;
    timeout_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (consume) begin
          cmd_d   = slot_cmd_q;
          timer_d = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (lcd_state != IDLE_CODE) begin
          timer_d = '0;
          state_d = S_HOLD;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          timer_d   = '0;
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_HOLD: begin
        if (timer_q == TW'(HOLD_CYCLES - 1)) begin
          timer_d = '0;
          state_d = S_DONE_WAIT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_DONE_WAIT: begin
        if (lcd_state == IDLE_CODE) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    lcdctl_d = ((state_d == S_ISSUE) || (state_d == S_HOLD)) ? cmd_d : 3'b000;
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      press_q    <= '0;
      for (int i = 0; i < NK; i++) db_cnt_q[i] <= '0;
      state_q    <= S_IDLE;
      cmd_q      <= 3'b000;
      timer_q    <= '0;
      slot_vld_q <= 1'b0;
      slot_cmd_q <= 3'b000;
      lcdctl_q   <= 3'b000;
      busy_q     <= 1'b0;
      dropped_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      sync1_q    <= keys;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      press_q    <= press_d;
      for (int i = 0; i < NK; i++) db_cnt_q[i] <= db_cnt_d[i];
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      timer_q    <= timer_d;
      slot_vld_q <= slot_vld_d;
      slot_cmd_q <= slot_cmd_d;
      lcdctl_q   <= lcdctl_d;
      busy_q     <= busy_d;
      dropped_q  <= dropped_d;
      timeout_q  <= timeout_d;
    end
  end

  assign lcdctl  = lcdctl_q;
  assign busy    = busy_q;
  assign dropped = dropped_q;
  assign timeout = timeout_q;

endmodule
